// File: rtl/reg_bus_ctrl.sv
// Register-bus initiator: sequences one-hot readA/readB/writeC strobes and D for one request at a time.
// Latency: WRITE 2, READ/MOVE 4, reject 1 cycle to rsp_valid; requests arriving while busy are ignored.
module reg_bus_ctrl #(
    parameter  int NREG = 8,
    parameter  int W    = 16,
    localparam int IW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [IW-1:0]   req_src_a,
    input  logic [IW-1:0]   req_src_b,
    input  logic [IW-1:0]   req_dst,
    input  logic [W-1:0]    req_data,
    output logic [NREG-1:0] readA,
    output logic [NREG-1:0] readB,
    output logic [NREG-1:0] writeC,
    output logic [W-1:0]    D,
    output logic [IW-1:0]   a_sel,
    output logic [IW-1:0]   b_sel,
    input  logic [W-1:0]    bus_a,
    input  logic [W-1:0]    bus_b,
    output logic            rsp_valid,
    output logic [W-1:0]    rsp_a,
    output logic [W-1:0]    rsp_b,
    output logic            rsp_err
);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam int         NSLOT    = 1 << IW;
    // Bit i set when index i addresses a real register.
    localparam logic [NSLOT-1:0] IDX_OK = NSLOT'((1 << NREG) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_CAPA, S_CAPB, S_WR, S_RSP, S_ERR
    } state_t;

    state_t          state, nxt;
    logic [1:0]      op_q;
    logic [IW-1:0]   sa_q, sb_q, dst_q;
    logic [W-1:0]    data_q;
    logic            bad_idx;

    logic [1:0]      f_op;
    logic [IW-1:0]   f_sa, f_dst;
    logic [W-1:0]    f_data;

    logic [NREG-1:0] readA_d, readB_d, writeC_d;
    logic [W-1:0]    D_d, rsp_a_d, rsp_b_d;
    logic [IW-1:0]   a_sel_d, b_sel_d;
    logic            rsp_valid_d, rsp_err_d, req_ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req_valid) begin
                op_q   <= req_op;
                sa_q   <= req_src_a;
                sb_q   <= req_src_b;
                dst_q  <= req_dst;
                data_q <= req_data;
            end
        end
    end

    always_comb begin
        bad_idx = 1'b0;
        case (req_op)
            OP_READ:  bad_idx = !IDX_OK[req_src_a] || !IDX_OK[req_src_b];
            OP_WRITE: bad_idx = !IDX_OK[req_dst];
            OP_MOVE:  bad_idx = !IDX_OK[req_src_a] || !IDX_OK[req_dst];
            default:  bad_idx = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_op == 2'b11 || bad_idx) nxt = S_ERR;
                    else if (req_op == OP_WRITE)    nxt = S_WR;
                    else                            nxt = S_RDA;
                end
            end
            S_RDA:   nxt = (op_q == OP_MOVE) ? S_CAPA : S_RDB;
            S_RDB:   nxt = S_CAPB;
            S_CAPB:  nxt = S_RSP;
            S_CAPA:  nxt = S_WR;
            S_WR:    nxt = S_RSP;
            S_RSP:   nxt = S_IDLE;
            S_ERR:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the next state;
    // in IDLE the request fields have not been latched yet and come straight from the port.
    always_comb begin
        f_op   = (state == S_IDLE) ? req_op    : op_q;
        f_sa   = (state == S_IDLE) ? req_src_a : sa_q;
        f_dst  = (state == S_IDLE) ? req_dst   : dst_q;
        f_data = (state == S_IDLE) ? req_data  : data_q;

        readA_d     = (nxt == S_RDA) ? (NREG'(1) << f_sa)  : '0;
        readB_d     = (nxt == S_RDB) ? (NREG'(1) << sb_q)  : '0;
        writeC_d    = (nxt == S_WR)  ? (NREG'(1) << f_dst) : '0;
        a_sel_d     = (nxt == S_RDA) ? f_sa : a_sel;
        b_sel_d     = (nxt == S_RDB) ? sb_q : b_sel;
        rsp_valid_d = (nxt == S_RSP) || (nxt == S_ERR);
        rsp_err_d   = (nxt == S_ERR);
        req_ready_d = (nxt == S_IDLE);

        D_d = D;
        if (nxt == S_WR) D_d = (f_op == OP_MOVE) ? bus_a : f_data;

        rsp_a_d = rsp_a;
        if (state == S_RDB || state == S_CAPA)      rsp_a_d = bus_a;
        else if (state == S_WR && op_q == OP_WRITE) rsp_a_d = data_q;

        rsp_b_d = (state == S_CAPB) ? bus_b : rsp_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readA     <= '0;
            readB     <= '0;
            writeC    <= '0;
            D         <= '0;
            a_sel     <= '0;
            b_sel     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            req_ready <= 1'b1;
        end else begin
            readA     <= readA_d;
            readB     <= readB_d;
            writeC    <= writeC_d;
            D         <= D_d;
            a_sel     <= a_sel_d;
            b_sel     <= b_sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_a     <= rsp_a_d;
            rsp_b     <= rsp_b_d;
            req_ready <= req_ready_d;
        end
    end
endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: register-bank model, directed requests, scoreboard-checked responses.
module tb_reg_bus_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid2;
    logic [1:0]  req_op;
    logic [2:0]  req_src_a, req_src_b, req_dst;
    logic [15:0] req_data;
    logic        req_ready, req_ready2;
    logic [7:0]  readA, readB, writeC;
    logic [5:0]  readA2, readB2, writeC2;
    logic [15:0] D, D2, bus_a, bus_b, rsp_a, rsp_b, rsp_a2, rsp_b2;
    logic [2:0]  a_sel, b_sel, a_sel2, b_sel2;
    logic        rsp_valid, rsp_err, rsp_valid2, rsp_err2;
    logic [15:0] zero16 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [15:0] a;
        logic [15:0] b;
        int          at;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_ctrl #(.NREG(8), .W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
        .req_data(req_data), .readA(readA), .readB(readB), .writeC(writeC), .D(D),
        .a_sel(a_sel), .b_sel(b_sel), .bus_a(bus_a), .bus_b(bus_b),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_err(rsp_err)
    );

    reg_bus_ctrl #(.NREG(6), .W(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op), .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst),
        .req_data(req_data), .readA(readA2), .readB(readB2), .writeC(writeC2), .D(D2),
        .a_sel(a_sel2), .b_sel(b_sel2), .bus_a(zero16), .bus_b(zero16),
        .rsp_valid(rsp_valid2), .rsp_a(rsp_a2), .rsp_b(rsp_b2), .rsp_err(rsp_err2)
    );

    // Register bank: writeC beats readA beats readB; A/B outputs are registered per register.
    logic [15:0] regs [8];
    logic [15:0] aout [8];
    logic [15:0] bout [8];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
                aout[i] <= '0;
                bout[i] <= '0;
            end
            regs[2] <= 16'h1234;
            regs[5] <= 16'hABCD;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (writeC[i])     regs[i] <= D;
                else if (readA[i]) aout[i] <= regs[i];
                else if (readB[i]) bout[i] <= regs[i];
            end
        end
    end
    assign bus_a = aout[a_sel];
    assign bus_b = bout[b_sel];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: strobe exclusivity every cycle, response compared against the scoreboard.
    initial forever begin
        @(negedge clk);
        chk("strobe_onehot", 32'($countones(readA | readB | writeC) <= 1), 32'd1);
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_a", 32'(rsp_a), 32'(e.a));
                chk("rsp_b", 32'(rsp_b), 32'(e.b));
                chk("rsp_cycle", cyc, e.at);
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 with req_valid still high.
    task automatic issue(input logic [1:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] dst, input logic [15:0] data, input int lat,
                         input logic e_err, input logic [15:0] ea, input logic [15:0] eb,
                         output int acc);
        int n = 0;
        req_op = op; req_src_a = sa; req_src_b = sb; req_dst = dst; req_data = data;
        req_valid = 1'b1;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        sbq.push_back('{e_err, ea, eb, cyc + lat});
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acc1, acc2, n;
        rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
        req_op = '0; req_src_a = '0; req_src_b = '0; req_dst = '0; req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", 32'({readA, readB, writeC}), 32'd0);
        chk("rst_D_sel", 32'({D, a_sel, b_sel}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_a}), 32'd0);
        chk("rst_rsp_b", 32'(rsp_b), 32'd0);
        chk("rst6_zero", 32'(|{readA2, readB2, writeC2, D2, a_sel2, b_sel2, rsp_a2, rsp_b2,
                               rsp_valid2, rsp_err2}), 32'd0);
        chk("rst6_ready", 32'(req_ready2), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // WRITE R3 <= BEEF
        issue(2'b01, 3'd0, 3'd0, 3'd3, 16'hBEEF, 2, 1'b0, 16'hBEEF, 16'h0000, acc1);
        req_valid = 1'b0;
        chk("wr_c1_writeC", 32'(writeC), 32'h08);
        chk("wr_c1_D", 32'(D), 32'hBEEF);
        chk("wr_c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("wr_c2_writeC", 32'(writeC), 32'h00);
        chk("wr_c2_D_hold", 32'(D), 32'hBEEF);

        // READ A=R2, B=R5
        issue(2'b00, 3'd2, 3'd5, 3'd0, 16'h0, 4, 1'b0, 16'h1234, 16'hABCD, acc1);
        req_valid = 1'b0;
        chk("rd_c1_readA", 32'({readA, readB}), 32'h0400);
        chk("rd_c1_a_sel", 32'(a_sel), 32'd2);
        @(negedge clk);
        chk("rd_c2_readB", 32'({readA, readB}), 32'h0020);
        chk("rd_c2_b_sel", 32'(b_sel), 32'd5);
        @(negedge clk);
        chk("rd_c3_none", 32'({readA, readB, writeC}), 32'd0);

        // MOVE R5 -> R0, then read R0 back
        issue(2'b10, 3'd5, 3'd0, 3'd0, 16'h0, 4, 1'b0, 16'hABCD, 16'hABCD, acc1);
        req_valid = 1'b0;
        chk("mv_c1_readA", 32'({readA, readB, writeC}), 32'h200000);
        @(negedge clk);
        chk("mv_c2_none", 32'({readA, readB, writeC}), 32'd0);
        @(negedge clk);
        chk("mv_c3_writeC", 32'(writeC), 32'h01);
        chk("mv_c3_D", 32'(D), 32'hABCD);
        issue(2'b00, 3'd0, 3'd3, 3'd0, 16'h0, 4, 1'b0, 16'hABCD, 16'hBEEF, acc1);
        req_valid = 1'b0;

        // Reserved op: rejected in cycle 1, response data unchanged
        issue(2'b11, 3'd1, 3'd1, 3'd1, 16'h5555, 1, 1'b1, 16'hABCD, 16'hBEEF, acc1);
        req_valid = 1'b0;
        chk("err_no_strobe", 32'({readA, readB, writeC}), 32'd0);

        // NREG=6 instance: dst=7 is out of range
        n = 0;
        while (!req_ready2 && n < 40) begin @(negedge clk); n++; end
        req_op = 2'b01; req_dst = 3'd7; req_data = 16'h7777; req_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid2 = 1'b0;
        chk("n6_rsp_valid", 32'(rsp_valid2), 32'd1);
        chk("n6_rsp_err", 32'(rsp_err2), 32'd1);
        chk("n6_no_strobe", 32'({readA2, readB2, writeC2}), 32'd0);
        chk("n6_rsp_data", 32'({rsp_a2, rsp_b2}), 32'd0);
        @(negedge clk);
        chk("n6_pulse_end", 32'(rsp_valid2), 32'd0);
        chk("n6_ready", 32'(req_ready2), 32'd1);

        // Back-to-back READs with req_valid held high
        issue(2'b00, 3'd2, 3'd5, 3'd0, 16'h0, 4, 1'b0, 16'h1234, 16'hABCD, acc1);
        issue(2'b00, 3'd3, 3'd2, 3'd0, 16'h0, 4, 1'b0, 16'hBEEF, 16'h1234, acc2);
        req_valid = 1'b0;
        chk("b2b_gap", acc2 - acc1, 5);

        // Reset during cycle 2 of a MOVE R2 -> R6
        n = 0;
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        req_op = 2'b10; req_src_a = 3'd2; req_dst = 3'd6; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mvr_c1_readA", 32'(readA), 32'h04);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mvr_rst_strobes", 32'({readA, readB, writeC}), 32'd0);
        chk("mvr_rst_rsp", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mvr_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mvr_no_writeC", 32'({writeC, rsp_valid}), 32'd0);
        end
        chk("mvr_R6_untouched", 32'(regs[6]), 32'd0);
        chk("sb_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
